// File: rtl/cache_write_buffer.sv
// Posted write buffer between the data cache and memory: FIFO drain over a
// req/ack handshake, same-word coalescing, and read-miss forwarding.
module cache_write_buffer #(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned ADDRWIDTH = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PTRW      = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enq_valid,
   input  logic [ADDRWIDTH-1:0] enq_addr,
   input  logic [DATAWIDTH-1:0] enq_data,
   output logic                 enq_ready,
   input  logic [ADDRWIDTH-1:0] lookup_addr,
   output logic                 lookup_hit,
   output logic [DATAWIDTH-1:0] lookup_data,
   output logic                 mem_req,
   output logic [ADDRWIDTH-1:0] mem_addr,
   output logic [DATAWIDTH-1:0] mem_data,
   input  logic                 mem_ack,
   input  logic                 flush,
   output logic                 drained,
   output logic [PTRW:0]        count,
   output logic                 full
);

   localparam int unsigned CW = PTRW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   state_e                 state_q;
   logic [ADDRWIDTH-1:0]   addr_q [DEPTH];
   logic [DATAWIDTH-1:0]   data_q [DEPTH];
   logic [DEPTH-1:0]       valid_q;
   logic [PTRW-1:0]        head_q;
   logic [PTRW-1:0]        tail_q;
   logic [CW-1:0]          count_q;
   logic [CW-1:0]          count_d;

   logic                   coal_hit;
   logic [PTRW-1:0]        coal_idx;
   logic                   enq_fire;
   logic                   alloc;
   logic                   pop;
   logic                   lk_hit;
   logic [DATAWIDTH-1:0]   lk_data;

   // Coalesce target: a valid entry with the same address, never the in-flight head
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && addr_q[i] == enq_addr &&
             !(state_q == REQ && PTRW'(i) == head_q)) begin
            coal_hit = 1'b1;
            coal_idx = PTRW'(i);
         end
      end
   end

   // Read-miss forwarding: a newer duplicate wins over the in-flight head
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && addr_q[i] == lookup_addr &&
             (!lk_hit || PTRW'(i) != head_q)) begin
            lk_hit  = 1'b1;
            lk_data = data_q[i];
         end
      end
   end

   // Handshake decode and next count; a pop never frees a slot for the same-cycle enqueue
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      enq_ready = !flush && (!full || coal_hit);
      enq_fire  = enq_valid && enq_ready;
      alloc     = enq_fire && !coal_hit;
      pop       = (state_q == REQ) && mem_ack;
      count_d   = count_q + CW'(alloc) - CW'(pop);
   end

   // Storage, pointers, count and drain state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTRW'(1);
         end
         if (enq_fire) begin
            if (coal_hit) begin
               data_q[coal_idx] <= enq_data;
            end else begin
               addr_q[tail_q]  <= enq_addr;
               data_q[tail_q]  <= enq_data;
               valid_q[tail_q] <= 1'b1;
               tail_q          <= tail_q + PTRW'(1);
            end
         end
         count_q <= count_d;
         case (state_q)
            IDLE:    if (count_q != '0) state_q <= REQ;
            REQ:     if (pop && count_d == '0) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Head entry cannot be rewritten while in flight, so these hold until ack
   always_comb begin
      mem_req     = (state_q == REQ);
      mem_addr    = mem_req ? addr_q[head_q] : '0;
      mem_data    = mem_req ? data_q[head_q] : '0;
      lookup_hit  = lk_hit;
      lookup_data = lk_data;
      count       = count_q;
      drained     = (count_q == '0) && (state_q == IDLE);
   end

endmodule
